// File: rtl/bcd_arb_pkg.sv
// Shared types and defaults for the stopwatch BCD conversion arbiter.
package bcd_arb_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, WRITE} state_t;

  localparam int NREQ   = 3;
  localparam int BIN_W  = 14;
  localparam int DIGITS = 4;

  function automatic int pow10(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

endpackage

// File: rtl/bcd_conv_arbiter_if.sv
// Channel-side bundle of the BCD arbiter: requests/values in, grants/results out.
interface bcd_conv_arbiter_if #(
  parameter int NREQ   = bcd_arb_pkg::NREQ,
  parameter int BIN_W  = bcd_arb_pkg::BIN_W,
  parameter int DIGITS = bcd_arb_pkg::DIGITS
);
  logic [NREQ-1:0]          req;
  logic [NREQ*BIN_W-1:0]    bin_in;
  logic [NREQ-1:0]          grant;
  logic [NREQ*DIGITS*4-1:0] bcd_out;
  logic [NREQ-1:0]          done;
  logic                     busy;
  logic [NREQ-1:0]          ovf;

  modport master (output req, bin_in, input grant, bcd_out, done, busy, ovf);
  modport slave  (input req, bin_in, output grant, bcd_out, done, busy, ovf);
endinterface

// File: rtl/bcd_shift_engine.sv
// Iterative shift-add-3 binary-to-BCD core: loads on start, takes BIN_W shift cycles.
// done is high during the final shift cycle; bcd holds the result from the next cycle on.
module bcd_shift_engine #(
  parameter int BIN_W  = bcd_arb_pkg::BIN_W,
  parameter int DIGITS = bcd_arb_pkg::DIGITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic [DIGITS*4-1:0]   bcd,
  output logic                  done
);
  localparam int BCD_W = DIGITS * 4;
  localparam int SCR_W = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);

  logic [SCR_W-1:0] scratch;
  logic [SCR_W-1:0] scratch_nxt;
  logic [CNT_W-1:0] step;
  logic             run;

  // Add-3 correction feeds straight into the shift; the top-digit carry falls off.
  always_comb begin
    scratch_nxt = scratch;
    for (int d = 0; d < DIGITS; d++) begin
      if (scratch_nxt[BIN_W + 4*d +: 4] >= 4'd5)
        scratch_nxt[BIN_W + 4*d +: 4] = scratch_nxt[BIN_W + 4*d +: 4] + 4'd3;
    end
    scratch_nxt = scratch_nxt << 1;
  end

  assign done = run && (step == CNT_W'(BIN_W - 1));
  assign bcd  = scratch[SCR_W-1 -: BCD_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      scratch <= '0;
      step    <= '0;
      run     <= 1'b0;
    end else if (start) begin
      scratch <= {{BCD_W{1'b0}}, bin};
      step    <= '0;
      run     <= 1'b1;
    end else if (run) begin
      scratch <= scratch_nxt;
      step    <= step + 1'b1;
      if (done) run <= 1'b0;
    end
  end

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Round-robin share of one BCD engine across NREQ channels; grant+1 -> done in BIN_W+1 cycles,
// one conversion per BIN_W+2 cycles; requests wait (held level) until granted. Option: BCD_SAT_EN.
module bcd_conv_arbiter #(
  parameter int NREQ   = bcd_arb_pkg::NREQ,
  parameter int BIN_W  = bcd_arb_pkg::BIN_W,
  parameter int DIGITS = bcd_arb_pkg::DIGITS
) (
  input  logic               clk,
  input  logic               rst,
  bcd_conv_arbiter_if.slave  bus
);
  import bcd_arb_pkg::*;

  localparam int BCD_W = DIGITS * 4;
  localparam int PTR_W = $clog2(NREQ);

  state_t              state, state_nxt;
  logic [PTR_W-1:0]    ptr, win, win_q;
  logic                start;
  int                  idx;
  logic [BIN_W-1:0]    win_bin, eng_bin;
  logic [BCD_W-1:0]    eng_bcd;
  logic                eng_done;
  logic [NREQ-1:0]     grant_q, done_q;
  logic [NREQ*BCD_W-1:0] bcd_q;

  // Scan downward so the lowest offset from ptr is the last (winning) assignment.
  always_comb begin
    win = ptr;
    idx = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (bus.req[idx]) win = PTR_W'(idx);
    end
  end

  assign win_bin = bus.bin_in[win*BIN_W +: BIN_W];

`ifdef BCD_SAT_EN
  localparam int LIMIT = pow10(DIGITS);
  logic            in_ovf, sat_q;
  logic [NREQ-1:0] ovf_q;
  assign in_ovf  = int'(win_bin) >= LIMIT;
  assign eng_bin = in_ovf ? BIN_W'(LIMIT - 1) : win_bin;
  assign bus.ovf = ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sat_q <= 1'b0;
      ovf_q <= '0;
    end else begin
      if (start) sat_q <= in_ovf;
      if (state == WRITE) begin
        for (int i = 0; i < NREQ; i++)
          if (win_q == PTR_W'(i)) ovf_q[i] <= sat_q;
      end
    end
  end
`else
  assign eng_bin = win_bin;
  assign bus.ovf = '0;
`endif

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    case (state)
      IDLE: begin
        if (|bus.req) begin
          start     = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT:   if (eng_done) state_nxt = WRITE;
      WRITE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      win_q   <= '0;
      grant_q <= '0;
      done_q  <= '0;
      bcd_q   <= '0;
    end else begin
      state   <= state_nxt;
      grant_q <= '0;
      done_q  <= '0;
      if (start) begin
        win_q   <= win;
        grant_q <= NREQ'(1) << win;
      end
      if (state == WRITE) begin
        for (int i = 0; i < NREQ; i++)
          if (win_q == PTR_W'(i)) bcd_q[i*BCD_W +: BCD_W] <= eng_bcd;
        done_q <= NREQ'(1) << win_q;
        ptr    <= (win_q == PTR_W'(NREQ - 1)) ? '0 : win_q + 1'b1;
      end
    end
  end

  bcd_shift_engine #(.BIN_W(BIN_W), .DIGITS(DIGITS)) u_engine (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (eng_bin),
    .bcd   (eng_bcd),
    .done  (eng_done)
  );

  assign bus.grant   = grant_q;
  assign bus.done    = done_q;
  assign bus.bcd_out = bcd_q;
  // The done cycle already sits in IDLE, so it is folded into busy explicitly.
  assign bus.busy    = (state != IDLE) | (|done_q);

endmodule
